// File: rtl/max7219_pkg.sv
// Shared MAX7219 link constants: register addresses and frame geometry.
// The display transmitter and this receiver use the same definitions.
package max7219_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous line, followed by a registered
// edge detector producing one-cycle rise/fall pulses.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] ff;
  logic              prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      ff   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      ff   <= {ff[STAGES-2:0], async_in};
      prev <= ff[STAGES-1];
      rise <= ff[STAGES-1] & ~prev;
      fall <= ~ff[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 serial receiver: assembles frames from sck/cs/din and mirrors the
// device register file, flagging each completed or truncated frame.
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIGIT_NUM   = 8,
  parameter int FRAME_BITS  = max7219_pkg::FRAME_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   max_sck,
  input  logic                   max_cs,
  input  logic                   max_din,
  output logic                   max_dout,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [3:0]             frame_addr,
  output logic [7:0]             frame_data,
  output logic [8*DIGIT_NUM-1:0] digits,
  output logic [7:0]             decode_mode,
  output logic [3:0]             intensity,
  output logic [2:0]             scan_limit,
  output logic                   shutdown_n,
  output logic                   display_test
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clock(clock), .reset(reset), .async_in(max_sck), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clock(clock), .reset(reset), .async_in(max_cs), .rise(cs_rise), .fall(cs_fall)
  );

  // din gets one extra flop so it lines up with the registered edge pulses
  logic [SYNC_STAGES-1:0] din_ff;
  logic                   din_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      din_ff <= '0;
      din_d  <= 1'b0;
    end else begin
      din_ff <= {din_ff[SYNC_STAGES-2:0], max_din};
      din_d  <= din_ff[SYNC_STAGES-1];
    end
  end

  rx_state_e state_q, state_d;
  logic      clear_en, shift_en, dout_en, latch_en;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clear_en = 1'b0;
    shift_en = 1'b0;
    dout_en  = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d  = ST_SHIFT;
          clear_en = 1'b1;
        end
      end
      ST_SHIFT: begin
        // a clock edge coinciding with the cs rise belongs to no frame
        shift_en = sck_rise & ~cs_rise;
        dout_en  = sck_fall;
        if (cs_rise) begin
          state_d  = ST_IDLE;
          latch_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [FRAME_BITS-1:0]     shreg;
  logic [CNT_W-1:0]          bit_cnt;
  logic [DIGIT_NUM-1:0][7:0] digit_q;
  logic [3:0]                lat_addr;
  logic [7:0]                lat_data;
  logic                      frame_ok;

  assign lat_addr = shreg[11:8];
  assign lat_data = shreg[7:0];
  assign frame_ok = latch_en && (bit_cnt == CNT_W'(FRAME_BITS));
  assign digits   = digit_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      max_dout     <= 1'b0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      frame_addr   <= '0;
      frame_data   <= '0;
      digit_q      <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
    end else begin
      frame_valid <= frame_ok;
      frame_err   <= latch_en && !frame_ok;
      if (clear_en) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
      if (shift_en) begin
        shreg <= {shreg[FRAME_BITS-2:0], din_d};
        if (bit_cnt != CNT_W'(FRAME_BITS)) bit_cnt <= bit_cnt + 1'b1;
      end
      if (dout_en) max_dout <= shreg[FRAME_BITS-1];
      if (frame_ok) begin
        frame_addr <= lat_addr;
        frame_data <= lat_data;
        for (int i = 0; i < DIGIT_NUM; i++)
          if (lat_addr == REG_DIGIT0 + 4'(i)) digit_q[i] <= lat_data;
        case (lat_addr)
          REG_DECODE:    decode_mode  <= lat_data;
          REG_INTENSITY: intensity    <= lat_data[3:0];
          REG_SCANLIMIT: scan_limit   <= lat_data[2:0];
          REG_SHUTDOWN:  shutdown_n   <= lat_data[0];
          REG_TEST:      display_test <= lat_data[0];
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_max7219_rx.sv
// Scoreboard bench for max7219_rx: directed frames push expected register
// snapshots; a monitor pops and compares on every frame_valid/frame_err pulse.
module tb_max7219_rx;

  localparam int SYNC = 2;
  localparam int PH   = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        max_sck = 1'b0;
  logic        max_cs = 1'b1;
  logic        max_din = 1'b0;
  logic        max_dout, frame_valid, frame_err;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic [63:0] digits;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n, display_test;

  max7219_rx #(.SYNC_STAGES(SYNC), .DIGIT_NUM(8), .FRAME_BITS(16)) dut (
    .clock(clock), .reset(reset), .max_sck(max_sck), .max_cs(max_cs), .max_din(max_din),
    .max_dout(max_dout), .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_addr(frame_addr), .frame_data(frame_data), .digits(digits),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          err;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [63:0] dig;
    logic [7:0]  dec;
    logic [3:0]  inten;
    logic [2:0]  scan;
    logic        sd;
    logic        tst;
    int          rc;
  } exp_t;

  exp_t q[$];

  logic [63:0] m_dig;
  logic [7:0]  m_dec, m_data;
  logic [3:0]  m_int, m_addr;
  logic [2:0]  m_scan;
  logic        m_sd, m_tst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dig = '0; m_dec = '0; m_data = '0; m_int = '0; m_addr = '0; m_scan = '0;
    m_sd = 1'b0; m_tst = 1'b0;
  endtask

  task automatic apply(input logic [3:0] a, input logic [7:0] d);
    m_addr = a;
    m_data = d;
    case (a)
      4'h9: m_dec = d;
      4'hA: m_int = d[3:0];
      4'hB: m_scan = d[2:0];
      4'hC: m_sd = d[0];
      4'hF: m_tst = d[0];
      default: if (a >= 4'h1 && a <= 4'h8) m_dig[8*(int'(a)-1) +: 8] = d;
    endcase
  endtask

  function automatic exp_t snap(input bit err, input int rc);
    exp_t e;
    e.err = err; e.addr = m_addr; e.data = m_data; e.dig = m_dig; e.dec = m_dec;
    e.inten = m_int; e.scan = m_scan; e.sd = m_sd; e.tst = m_tst; e.rc = rc;
    return e;
  endfunction

  // Drives n bits of val MSB first; abort=1 pulls reset instead of raising cs.
  task automatic send(input logic [31:0] val, input int n, input bit abort);
    logic [31:0] hist;
    hist = '0;
    @(negedge clock);
    max_cs = 1'b0;
    repeat (PH) @(negedge clock);
    for (int k = 1; k <= n; k++) begin
      hist[k-1] = val[n-k];
      max_din   = val[n-k];
      repeat (PH) @(negedge clock);
      max_sck = 1'b1;
      repeat (PH) @(negedge clock);
      max_sck = 1'b0;
      repeat (PH) @(negedge clock);
      chk("dout", max_dout, (k >= 16) ? hist[k-16] : 1'b0);
    end
    if (abort) begin
      reset  = 1'b1;
      max_cs = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      model_reset();
    end else begin
      if (n >= 16) begin
        apply(val[11:8], val[7:0]);
        q.push_back(snap(1'b0, cyc));
      end else begin
        q.push_back(snap(1'b1, cyc));
      end
      max_cs = 1'b1;
    end
    for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clock);
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (!reset && (frame_valid || frame_err)) begin
      chk("valid_err_exclusive", frame_valid & frame_err, 1'b0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse got valid=%0b err=%0b want none", frame_valid, frame_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("frame_err", frame_err, e.err);
        chk("frame_valid", frame_valid, !e.err);
        chk("latency", cyc - e.rc, SYNC + 2);
        chk("frame_addr", frame_addr, e.addr);
        chk("frame_data", frame_data, e.data);
        chk("digits", digits, e.dig);
        chk("decode_mode", decode_mode, e.dec);
        chk("intensity", intensity, e.inten);
        chk("scan_limit", scan_limit, e.scan);
        chk("shutdown_n", shutdown_n, e.sd);
        chk("display_test", display_test, e.tst);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_regs", {digits, decode_mode, intensity, scan_limit, shutdown_n, display_test}, '0);
    chk("rst_frame", {frame_valid, frame_err, frame_addr, frame_data, max_dout}, '0);

    send(32'h0C01, 16, 1'b0);
    chk("shutdown_on", shutdown_n, 1'b1);

    send(32'h0A07, 16, 1'b0);
    send(32'h0B07, 16, 1'b0);
    send(32'h0905, 16, 1'b0);
    chk("intensity_7", intensity, 4'h7);
    chk("scan_7", scan_limit, 3'h7);
    chk("decode_05", decode_mode, 8'h05);

    send(32'h03A5, 16, 1'b0);
    send(32'h0000, 16, 1'b0);
    chk("digit2_a5", digits[23:16], 8'hA5);

    send(32'h0D55, 16, 1'b0);
    send(32'h0ABC, 12, 1'b0);
    chk("short_addr_kept", frame_addr, 4'hD);

    send(32'hF0F01, 20, 1'b0);
    chk("test_on", display_test, 1'b1);

    send(32'h01FF >> 8, 8, 1'b1);
    chk("abort_regs", {digits, decode_mode, intensity, scan_limit, shutdown_n, display_test}, '0);
    send(32'h0142, 16, 1'b0);
    chk("digit0_42", digits[7:0], 8'h42);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_rx.md
Name: max7219_rx

Overview:
- Receive-side model of the MAX7219 3-wire serial link (sck/cs/din) that the display driver transmits on.
- Samples the three lines in the system clock domain and assembles 16-bit frames.
- Decodes each frame into a shadow copy of the MAX7219 register file and flags every completed frame.
- Used for on-board loopback checking of the display path and as the golden-side decoder in display benches.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (min 2).
- DIGIT_NUM, 8, number of digit registers mirrored (addresses 1..DIGIT_NUM, max 8).
- FRAME_BITS, 16, bits per frame.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- max_sck  in  1  serial clock from display driver, asynchronous to clock
- max_cs  in  1  chip select, active low, asynchronous
- max_din  in  1  serial data, MSB first, asynchronous
- max_dout  out  1  daisy-chain output: bit leaving the shift register
- frame_valid  out  1  one-cycle pulse, a well-formed frame was latched
- frame_err  out  1  one-cycle pulse, cs rose with fewer than FRAME_BITS bits
- frame_addr  out  4  address nibble (bits 11:8) of the last valid frame
- frame_data  out  8  data byte (bits 7:0) of the last valid frame
- digits  out  8*DIGIT_NUM  digit registers; digit n occupies [8n+7:8n]
- decode_mode  out  8  register 0x9
- intensity  out  4  register 0xA, bits 3:0
- scan_limit  out  3  register 0xB, bits 2:0
- shutdown_n  out  1  register 0xC, bit 0 (0 = shutdown)
- display_test  out  1  register 0xF, bit 0

Behaviour:
- Reset (clock edge with reset=1):
  - All outputs become 0, including digits, decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_addr, frame_data and max_dout.
  - Shift register and bit count clear; synchronizer flops clear to sck=0, cs=1, din=0.
  - Reset mid-frame aborts the frame: no frame_valid and no frame_err for it.
- Input sampling:
  - Each input passes through a SYNC_STAGES synchronizer followed by one edge-detect flop.
  - The driver's sck must be at most clock/4, with high and low phases of at least 2 clock cycles each.
- States:
  - IDLE: synced cs is high.
  - SHIFT: synced cs is low.
  - IDLE->SHIFT on the synced cs falling edge; this clears the bit count and the shift register.
  - SHIFT->IDLE on the synced cs rising edge.
- Shifting (SHIFT only):
  - On a synced sck rising edge: shreg <= {shreg[14:0], din_sync}.
  - bit_cnt increments and saturates at FRAME_BITS.
  - Sck edges while in IDLE are ignored.
- Daisy chain: max_dout <= shreg[15], updated on the synced sck falling edge, in SHIFT only.
- Latch, on the synced cs rising edge:
  - bit_cnt == FRAME_BITS:
    - The cycle after the edge, frame_valid=1, frame_addr=shreg[11:8], frame_data=shreg[7:0], and the addressed register updates in that same cycle.
    - Total latency from the raw cs rise is SYNC_STAGES+2 clocks.
    - More than 16 sck edges: only the last 16 bits are kept (saturated count), so the frame is still valid.
  - bit_cnt < FRAME_BITS: frame_err=1 for one cycle; no register, frame_addr or frame_data update.
  - An sck rising edge detected in the same cycle as the cs rising edge is not shifted.
- Address decode (frame bits 15:12 are don't-care):
  - 0x0 no-op: frame_valid pulses, nothing else changes.
  - 0x1..DIGIT_NUM: digits[addr-1] <= data.
  - 0x9: decode_mode <= data.
  - 0xA: intensity <= data[3:0].
  - 0xB: scan_limit <= data[2:0].
  - 0xC: shutdown_n <= data[0].
  - 0xF: display_test <= data[0].
  - 0xD, 0xE, and digit addresses above DIGIT_NUM: frame_valid pulses, no register changes.
- Back-to-back frames: cs high for at least 2 clock cycles between frames.
  - frame_valid never pulses on consecutive cycles.
  - A new frame may start while the previous pulse is high.
- frame_valid and frame_err are never high together.

Decomposition:
- Shared package max7219_pkg:
  - Address constants REG_NOOP=0x0, REG_DIGIT0=0x1, REG_DECODE=0x9, REG_INTENSITY=0xA, REG_SCANLIMIT=0xB, REG_SHUTDOWN=0xC, REG_TEST=0xF.
  - FRAME_BITS=16.
  - The same constants serve the display transmitter.
- Sub-module sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiate it for sck and cs; din uses the synchronizer only.

Test Plan:
- Reset, then frame 0x0C01 -> frame_valid one cycle, frame_addr=0xC, frame_data=0x01, shutdown_n=1; latency SYNC_STAGES+2 clocks from cs rise.
- Frames 0x0A07, 0x0B07, 0x0905 -> intensity=7, scan_limit=7, decode_mode=0x05.
- Frame 0x03A5, then 0x0000 -> digits[23:16]=0xA5, no-op pulses frame_valid and leaves all registers unchanged.
- 12 bits then cs rise -> frame_err pulse, no frame_valid, registers unchanged.
- 20 bits 0xF_0F01 (frame 0x0F01 in the last 16 bits) -> display_test=1, frame_valid; max_dout shows the earlier bits delayed by 16 sck falling edges.
- Reset asserted after 8 bits of 0x01FF, released, then full frame 0x0142 -> no pulse from the aborted frame; digits[7:0]=0x42.
